// File: rtl/sevenseg_scan_decoder.sv
// Seven-segment scan readback: debounces each multiplexed digit, decodes it to hex and
// delivers whole frames over valid/ready. Define SEVENSEG_ACTIVE_LOW_EN for common-anode inputs.
module sevenseg_scan_decoder #(
   parameter int unsigned DIGITS        = 4,
   parameter int unsigned STABLE_CYCLES = 3
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [6:0]          seg,
   input  logic [DIGITS-1:0]   digit_en,
   input  logic                out_ready,
   output logic                out_valid,
   output logic [4*DIGITS-1:0] out_value,
   output logic [DIGITS-1:0]   out_err,
   output logic                overrun
);

   localparam logic [7:0] STABLE_C = 8'(STABLE_CYCLES);

   typedef enum logic [1:0] {IDLE, SETTLE, HOLD} state_t;

   state_t              state_q, state_d;
   logic [7:0]          cnt_q, cnt_d;
   logic [6:0]          seg_in, seg_q, seg_p_q;
   logic [DIGITS-1:0]   en_in, en_q, en_p_q;
   logic [4*DIGITS-1:0] cap_val_q, cap_val_d;
   logic [DIGITS-1:0]   cap_err_q, cap_err_d;
   logic [DIGITS-1:0]   mask_q, mask_d;
   logic                out_valid_q, out_valid_d;
   logic [4*DIGITS-1:0] out_value_q, out_value_d;
   logic [DIGITS-1:0]   out_err_q, out_err_d;
   logic                overrun_q, overrun_d;
   logic                onehot, changed, capture, frame_done, xfer, drop;
   logic [4:0]          glyph;

`ifdef SEVENSEG_ACTIVE_LOW_EN
   assign seg_in = ~seg;
   assign en_in  = ~digit_en;
`else
   assign seg_in = seg;
   assign en_in  = digit_en;
`endif

   // Returns {err, nibble}; unknown glyphs decode to nibble 0 with err set.
   function automatic logic [4:0] decode(input logic [6:0] s);
      case (s)
         7'h3F:   decode = 5'h00;
         7'h06:   decode = 5'h01;
         7'h5B:   decode = 5'h02;
         7'h4F:   decode = 5'h03;
         7'h66:   decode = 5'h04;
         7'h6D:   decode = 5'h05;
         7'h7D:   decode = 5'h06;
         7'h07:   decode = 5'h07;
         7'h7F:   decode = 5'h08;
         7'h6F:   decode = 5'h09;
         7'h77:   decode = 5'h0A;
         7'h7C:   decode = 5'h0B;
         7'h39:   decode = 5'h0C;
         7'h5E:   decode = 5'h0D;
         7'h79:   decode = 5'h0E;
         7'h71:   decode = 5'h0F;
         default: decode = 5'h10;
      endcase
   endfunction

   assign onehot  = (en_q != '0) && ((en_q & (en_q - DIGITS'(1))) == '0);
   assign changed = {seg_q, en_q} != {seg_p_q, en_p_q};
   assign glyph   = decode(seg_q);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         seg_q       <= '0;
         en_q        <= '0;
         seg_p_q     <= '0;
         en_p_q      <= '0;
         cap_val_q   <= '0;
         cap_err_q   <= '0;
         mask_q      <= '0;
         out_valid_q <= 1'b0;
         out_value_q <= '0;
         out_err_q   <= '0;
         overrun_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         seg_q       <= seg_in;
         en_q        <= en_in;
         seg_p_q     <= seg_q;
         en_p_q      <= en_q;
         cap_val_q   <= cap_val_d;
         cap_err_q   <= cap_err_d;
         mask_q      <= mask_d;
         out_valid_q <= out_valid_d;
         out_value_q <= out_value_d;
         out_err_q   <= out_err_d;
         overrun_q   <= overrun_d;
      end
   end

   // Counter holds the number of matching samples seen; capture fires once it has reached the threshold.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      capture = 1'b0;
      case (state_q)
         IDLE: begin
            cnt_d = '0;
            if (onehot) begin
               state_d = SETTLE;
               cnt_d   = 8'd1;
            end
         end
         SETTLE: begin
            if (!onehot) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else if (changed) begin
               cnt_d = 8'd1;
            end else if (cnt_q >= STABLE_C) begin
               capture = 1'b1;
               state_d = HOLD;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         HOLD: begin
            if (changed) begin
               state_d = onehot ? SETTLE : IDLE;
               cnt_d   = onehot ? 8'd1 : 8'd0;
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   always_comb begin
      cap_val_d   = cap_val_q;
      cap_err_d   = cap_err_q;
      mask_d      = mask_q;
      frame_done  = 1'b0;
      out_valid_d = out_valid_q;
      out_value_d = out_value_q;
      out_err_d   = out_err_q;
      overrun_d   = overrun_q;
      if (capture) begin
         for (int unsigned i = 0; i < DIGITS; i++) begin
            if (en_q[i]) begin
               cap_val_d[4*i +: 4] = glyph[3:0];
               cap_err_d[i]        = glyph[4];
               mask_d[i]           = 1'b1;
            end
         end
         frame_done = (mask_d == '1);
         if (frame_done) mask_d = '0;
      end
      xfer = out_valid_q && out_ready;
      drop = frame_done && out_valid_q && !out_ready;
      if (frame_done && !drop) begin
         out_valid_d = 1'b1;
         out_value_d = cap_val_d;
         out_err_d   = cap_err_d;
      end else if (xfer) begin
         out_valid_d = 1'b0;
      end
      if (drop)      overrun_d = 1'b1;
      else if (xfer) overrun_d = 1'b0;
   end

   assign out_valid = out_valid_q;
   assign out_value = out_value_q;
   assign out_err   = out_err_q;
   assign overrun   = overrun_q;

endmodule

// File: tb/tb_sevenseg_scan_decoder.sv
// Scoreboard bench for sevenseg_scan_decoder: directed digit sequences, expected frames queued
// by the stimulus and checked by a monitor on every accepted transfer.
module tb_sevenseg_scan_decoder;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [6:0]  seg = '0;
   logic [3:0]  digit_en = '0;
   logic        out_ready = 1'b1;
   logic        out_valid;
   logic [15:0] out_value;
   logic [3:0]  out_err;
   logic        overrun;

   typedef struct packed {
      logic [3:0]  err;
      logic [15:0] val;
   } frame_t;

   frame_t exp_q[$];
   int     tests = 0;
   int     fails = 0;

   always #5 clk = ~clk;

   sevenseg_scan_decoder #(.DIGITS(4), .STABLE_CYCLES(3)) dut (
      .clk       (clk),
      .rst       (rst),
      .seg       (seg),
      .digit_en  (digit_en),
      .out_ready (out_ready),
      .out_valid (out_valid),
      .out_value (out_value),
      .out_err   (out_err),
      .overrun   (overrun)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic drive(input int d, input logic [6:0] s, input int n);
      digit_en = 4'(1 << d);
      seg      = s;
      tick(n);
   endtask

   task automatic push(input logic [3:0] e, input logic [15:0] v);
      frame_t f;
      f.err = e;
      f.val = v;
      exp_q.push_back(f);
   endtask

   always @(negedge clk) begin : monitor
      frame_t e;
      if (!rst && out_valid && out_ready) begin
         tests++;
         if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL unexpected_frame: got err=%b value=%h expected no frame", out_err, out_value);
         end else begin
            e = exp_q.pop_front();
            if (out_err !== e.err || out_value !== e.val) begin
               fails++;
               $display("FAIL frame: got err=%b value=%h expected err=%b value=%h",
                        out_err, out_value, e.err, e.val);
            end
         end
      end
   end

   initial begin
      int vcnt;
      int lat;

      #1 rst = 1'b1;
      #2;
      chk("reset_valid",   32'(out_valid), 32'd0);
      chk("reset_value",   32'(out_value), 32'd0);
      chk("reset_err",     32'(out_err),   32'd0);
      chk("reset_overrun", 32'(overrun),   32'd0);
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;

      vcnt = 0;
      repeat (50) begin
         tick(1);
         if (out_valid) vcnt++;
      end
      chk("idle_no_valid", 32'(vcnt), 32'd0);

      // Full frame with latency measurement on the last digit.
      push(4'b0000, 16'h4321);
      drive(0, 7'h06, 5);
      drive(1, 7'h5B, 5);
      drive(2, 7'h4F, 5);
      digit_en = 4'b1000;
      seg      = 7'h66;
      lat      = 0;
      while (!out_valid && lat < 20) begin
         tick(1);
         lat++;
      end
      chk("latency", 32'(lat), 32'd5);
      tick(1);
      chk("single_pulse", 32'(out_valid), 32'd0);

      // Glitch: 7F shown too briefly, 6F is what must be captured.
      push(4'b0000, 16'h7910);
      drive(0, 7'h3F, 5);
      drive(1, 7'h06, 5);
      drive(2, 7'h7F, 2);
      drive(2, 7'h6F, 5);
      drive(3, 7'h07, 5);
      tick(2);

      push(4'b1010, 16'h0B02);
      drive(0, 7'h5B, 5);
      drive(1, 7'h00, 5);
      drive(2, 7'h7C, 5);
      drive(3, 7'h2A, 5);
      tick(2);

      // Backpressure: second frame dropped, first held.
      out_ready = 1'b0;
      push(4'b0000, 16'hEDCA);
      drive(0, 7'h77, 5);
      drive(1, 7'h39, 5);
      drive(2, 7'h5E, 5);
      drive(3, 7'h79, 5);
      chk("bp_first_valid", 32'(out_valid), 32'd1);
      chk("bp_no_overrun_yet", 32'(overrun), 32'd0);
      drive(0, 7'h71, 5);
      drive(1, 7'h7D, 5);
      drive(2, 7'h6D, 5);
      drive(3, 7'h3F, 5);
      chk("bp_held_valid", 32'(out_valid), 32'd1);
      chk("bp_held_value", 32'(out_value), 32'h0000EDCA);
      chk("bp_held_err",   32'(out_err),   32'd0);
      chk("bp_overrun",    32'(overrun),   32'd1);
      out_ready = 1'b1;
      tick(1);
      out_ready = 1'b0;
      chk("bp_valid_fell",   32'(out_valid), 32'd0);
      chk("bp_overrun_clr",  32'(overrun),   32'd0);

      // Non-one-hot enables between digits must not capture.
      out_ready = 1'b1;
      push(4'b0000, 16'h6543);
      drive(0, 7'h4F, 5);
      drive(1, 7'h66, 5);
      drive(2, 7'h6D, 5);
      digit_en = 4'b0011;
      seg      = 7'h7F;
      tick(10);
      chk("nonhot_no_valid", 32'(out_valid), 32'd0);
      drive(3, 7'h7D, 5);
      tick(2);

      // Completion on the same edge as a transfer of a pending frame.
      out_ready = 1'b0;
      push(4'b0000, 16'h3210);
      drive(0, 7'h3F, 5);
      drive(1, 7'h06, 5);
      drive(2, 7'h5B, 5);
      drive(3, 7'h4F, 5);
      push(4'b0000, 16'h7654);
      drive(0, 7'h66, 5);
      drive(1, 7'h6D, 5);
      drive(2, 7'h7D, 5);
      digit_en = 4'b1000;
      seg      = 7'h07;
      tick(4);
      out_ready = 1'b1;
      tick(1);
      out_ready = 1'b0;
      chk("simul_valid",   32'(out_valid), 32'd1);
      chk("simul_value",   32'(out_value), 32'h00007654);
      chk("simul_overrun", 32'(overrun),   32'd0);

      // Overrun again, then asynchronous reset clears everything at once.
      drive(0, 7'h3F, 5);
      drive(1, 7'h3F, 5);
      drive(2, 7'h3F, 5);
      drive(3, 7'h3F, 5);
      chk("ovr2_set",   32'(overrun),   32'd1);
      chk("ovr2_value", 32'(out_value), 32'h00007654);
      rst      = 1'b1;
      digit_en = '0;
      seg      = '0;
      #2;
      chk("midrst_valid",   32'(out_valid), 32'd0);
      chk("midrst_value",   32'(out_value), 32'd0);
      chk("midrst_err",     32'(out_err),   32'd0);
      chk("midrst_overrun", 32'(overrun),   32'd0);
      exp_q.delete();
      tick(2);
      rst       = 1'b0;
      out_ready = 1'b1;

      // Partial frame discarded by reset.
      drive(0, 7'h7F, 5);
      drive(1, 7'h7F, 5);
      digit_en = '0;
      rst      = 1'b1;
      tick(1);
      rst = 1'b0;
      push(4'b0000, 16'h2143);
      drive(2, 7'h06, 5);
      drive(3, 7'h5B, 5);
      drive(0, 7'h4F, 5);
      drive(1, 7'h66, 5);
      tick(3);
      chk("queue_drained", 32'(exp_q.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
